instr_fetch_unit: RTL and testbench

Fetch stage of the MIPS datapath. Holds the PC, fetches words from instruction memory over a ready-qualified request interface, and registers the fetched instruction for decode. Decode drives `Instr[15:0]` into the sign extender. This block consumes the extended immediate `SignImm` to form branch targets. Supports decode stall, taken-branch redirect and jump redirect; there is no branch delay slot.

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: PC, ready-qualified instruction fetch, decode register, branch/jump redirect.
// Optional jump redirect is compiled in when FETCH_JUMP_EN is defined.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic [31:0] SignImm,
   input  logic        JumpD,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic [31:0] ImemRdata,
   input  logic        ImemReady,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        InstrValidD
);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_q, buf_d;

   logic [31:0] pc_inc_s;
   logic [31:0] br_tgt_s;
   logic [31:0] redir_tgt_s;
   logic        take_jump_s;
   logic        acc_s;
   logic        redir_s;

   assign pc_inc_s = pc_q + 32'd4;
   assign br_tgt_s = pcplus4_q + {SignImm[29:0], 2'b00};

`ifdef FETCH_JUMP_EN
   logic [31:0] jmp_tgt_s;
   assign jmp_tgt_s   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
   assign take_jump_s = JumpD;
   assign redir_tgt_s = JumpD ? jmp_tgt_s : br_tgt_s;
`else
   logic unused_jump_s;
   assign unused_jump_s = JumpD;
   assign take_jump_s   = 1'b0;
   assign redir_tgt_s   = br_tgt_s;
`endif

   // A stalled decode only blocks fetch when it actually holds an instruction
   assign acc_s   = !valid_q || !StallD;
   assign redir_s = valid_q && !StallD && (PCSrcD || take_jump_s);

   assign ImemReq     = (state_q == S_FETCH) && !reset;
   assign ImemAddr    = pc_q;
   assign InstrD      = instr_q;
   assign PCPlus4D    = pcplus4_q;
   assign InstrValidD = valid_q;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0000_0000;
         pcplus4_q <= 32'h0000_0000;
         valid_q   <= 1'b0;
         buf_q     <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
         buf_q     <= buf_d;
      end
   end

   // Next-state logic; a redirect overrides everything, including a returning word
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      buf_d     = buf_q;
      if (redir_s) begin
         pc_d    = redir_tgt_s;
         valid_d = 1'b0;
         buf_d   = 32'h0000_0000;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (ImemReady && acc_s) begin
                  instr_d   = ImemRdata;
                  pcplus4_d = pc_inc_s;
                  valid_d   = 1'b1;
                  pc_d      = pc_inc_s;
                  state_d   = S_FETCH;
               end else if (ImemReady) begin
                  buf_d   = ImemRdata;
                  state_d = S_HOLD;
               end else if (valid_q && !StallD) begin
                  valid_d = 1'b0;
               end else begin
                  valid_d = valid_q;
               end
            end
            S_HOLD: begin
               if (!StallD) begin
                  instr_d   = buf_q;
                  pcplus4_d = pc_inc_s;
                  pc_d      = pc_inc_s;
                  valid_d   = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_HOLD;
               end
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan steps, then random stimulus against a
// queue-based reference model. Jump expectations follow FETCH_JUMP_EN.
module tb_instr_fetch_unit;

`ifdef FETCH_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk;
   logic        r_reset, r_stall, r_pcsrc, r_jump, r_ready;
   logic [31:0] r_simm, r_rdata;
   logic        ImemReq, InstrValidD;
   logic [31:0] ImemAddr, InstrD, PCPlus4D;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: architectural view of fetch
   logic [31:0] m_pc    = RST_PC;
   logic [31:0] m_instr = 32'h0;
   logic [31:0] m_pc4   = 32'h0;
   logic        m_valid = 1'b0;
   logic [31:0] m_held[$];

   instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(r_reset), .StallD(r_stall), .PCSrcD(r_pcsrc),
      .SignImm(r_simm), .JumpD(r_jump), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
      .ImemRdata(r_rdata), .ImemReady(r_ready), .InstrD(InstrD),
      .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] p;
      if (a == 32'h0040_0000) return 32'h0810_0010;
      p = a * 32'h9E37_79B9;
      return p ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input bit rst, input bit st, input bit ps, input bit jp,
                        input bit rdy, input logic [31:0] si);
      r_reset = rst; r_stall = st; r_pcsrc = ps; r_jump = jp; r_ready = rdy;
      r_simm  = si;  r_rdata = mem_word(m_pc);
   endtask

   task automatic model_step();
      bit          jmp;
      bit          redirect;
      logic [31:0] w;
      jmp      = JUMP_EN && r_jump;
      redirect = m_valid && !r_stall && (r_pcsrc || jmp);
      if (r_reset) begin
         m_pc = RST_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_held.delete();
      end else if (redirect) begin
         if (jmp) m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
         else     m_pc = m_pc4 + r_simm * 32'd4;
         m_valid = 1'b0;
         m_held.delete();
      end else if (m_held.size() > 0) begin
         if (!r_stall) begin
            w = m_held.pop_front();
            m_instr = w; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
         end
      end else if (r_ready) begin
         if (!m_valid || !r_stall) begin
            m_instr = r_rdata; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
         end else begin
            m_held.push_back(r_rdata);
         end
      end else if (m_valid && !r_stall) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("m_req",   {31'h0, ImemReq},     {31'h0, !r_reset && m_held.size() == 0});
      chk("m_addr",  ImemAddr,             m_pc);
      chk("m_instr", InstrD,               m_instr);
      chk("m_pc4",   PCPlus4D,             m_pc4);
      chk("m_valid", {31'h0, InstrValidD}, {31'h0, m_valid});
   endtask

   initial begin
      logic [31:0] hold_addr, w, jt, bt, tgt, si;
      // reset and sequential fetch
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick(); tick();
      chk("rst_req",   {31'h0, ImemReq}, 32'h0);
      chk("rst_addr",  ImemAddr, RST_PC);
      chk("rst_instr", InstrD, 32'h0);
      chk("rst_pc4",   PCPlus4D, 32'h0);
      chk("rst_valid", {31'h0, InstrValidD}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      #1;
      chk("first_req",  {31'h0, ImemReq}, 32'h1);
      chk("seq_addr0",  ImemAddr, 32'h0040_0000);
      tick();
      chk("seq_addr1",  ImemAddr, 32'h0040_0004);
      chk("seq_instr0", InstrD, 32'h0810_0010);
      chk("seq_pc4_0",  PCPlus4D, 32'h0040_0004);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("seq_addr2",  ImemAddr, 32'h0040_0008);
      chk("seq_pc4_1",  PCPlus4D, 32'h0040_0008);
      // backward branch
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
      tick();
      chk("bwd_addr",   ImemAddr, 32'h0040_0000);
      chk("bwd_bubble", {31'h0, InstrValidD}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("bwd_instr",  InstrD, 32'h0810_0010);
      chk("bwd_pc4",    PCPlus4D, 32'h0040_0004);
      // jump
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      tick();
      chk("jmp_addr", ImemAddr, JUMP_EN ? 32'h0040_0040 : 32'h0040_0008);
      // stall / hold
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      hold_addr = JUMP_EN ? 32'h0040_0044 : 32'h0040_000C;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
         tick();
         chk("hold_req",   {31'h0, ImemReq}, 32'h0);
         chk("hold_addr",  ImemAddr, hold_addr);
         chk("hold_pc4",   PCPlus4D, hold_addr);
         chk("hold_instr", InstrD, mem_word(hold_addr - 32'd4));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("rel_instr", InstrD, mem_word(hold_addr));
      chk("rel_pc4",   PCPlus4D, hold_addr + 32'd4);
      chk("rel_req",   {31'h0, ImemReq}, 32'h1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("rel_next",  InstrD, mem_word(hold_addr + 32'd4));
      // reset while holding
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("hrst_req",   {31'h0, ImemReq}, 32'h0);
      chk("hrst_addr",  ImemAddr, RST_PC);
      chk("hrst_instr", InstrD, 32'h0);
      chk("hrst_pc4",   PCPlus4D, 32'h0);
      chk("hrst_valid", {31'h0, InstrValidD}, 32'h0);
      // forward branch
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick(); tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0004);
      tick();
      chk("fwd_addr", ImemAddr, 32'h0040_0018);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      // jump and branch together
      w  = mem_word(32'h0040_0018);
      jt = {4'h0, w[25:0], 2'b00};
      bt = 32'h0040_001C + 32'd12;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0003);
      tick();
      tgt = JUMP_EN ? jt : bt;
      chk("both_addr", ImemAddr, tgt);
      // PC wrap
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      si = (32'hFFFF_FFFC - (tgt + 32'd4)) >> 2;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, si);
      tick();
      chk("wrap_tgt", ImemAddr, 32'hFFFF_FFFC);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("wrap_addr",  ImemAddr, 32'h0000_0000);
      chk("wrap_pc4",   PCPlus4D, 32'h0000_0000);
      chk("wrap_instr", InstrD, mem_word(32'hFFFF_FFFC));
      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         int v;
         v = int'($urandom_range(0, 63)) - 32;
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) != 0, 32'(v));
         tick();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
